// File: rtl/sdram_ref_pkg.sv
// Shared types and default constants for the SDRAM refresh scheduler.
package sdram_ref_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWED   = 2'd1,
    URGENT = 2'd2
  } ref_state_t;

  localparam int DEF_REF_INTERVAL  = 2236;
  localparam int DEF_MAX_POSTPONE  = 8;
  localparam int DEF_URGENT_THRESH = 6;

endpackage

// File: rtl/ref_interval_timer.sv
// tREFI interval counter: emits a one-cycle expiry strobe every REF_INTERVAL
// enabled cycles; clearing enable restarts a full interval.
module ref_interval_timer
  import sdram_ref_pkg::*;
#(
  parameter int CNT_W        = 12,
  parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  if (REF_INTERVAL < 2 || REF_INTERVAL > (1 << CNT_W)) begin : g_bad_interval
    $error("REF_INTERVAL must be in 2 .. 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(REF_INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments; combinational blocks use blocking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sdram_refresh_scheduler.sv
// Refresh scheduler: owed-refresh credit counter, req/ack handshake, urgency and
// sticky overflow. Define SDRAM_REF_PULLIN_EN to add idle-time refresh pull-in.
module sdram_refresh_scheduler
  import sdram_ref_pkg::*;
#(
  parameter int CNT_W         = 12,
  parameter int REF_INTERVAL  = DEF_REF_INTERVAL,
  parameter int MAX_POSTPONE  = DEF_MAX_POSTPONE,
  parameter int URGENT_THRESH = DEF_URGENT_THRESH,
  parameter int PEND_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              ref_ack,
  input  logic              bank_idle,
  output logic              ref_req,
  output logic              ref_urgent,
  output logic [PEND_W-1:0] pending,
  output logic              tick,
  output logic              overflow_err
`ifdef SDRAM_REF_PULLIN_EN
  ,
  output logic [PEND_W-1:0] pullin_cnt
`endif
);

  if (MAX_POSTPONE > (1 << PEND_W) - 1) begin : g_bad_pend_w
    $error("MAX_POSTPONE does not fit in PEND_W bits");
  end
  if (URGENT_THRESH < 1 || URGENT_THRESH > MAX_POSTPONE) begin : g_bad_thresh
    $error("URGENT_THRESH must be in 1 .. MAX_POSTPONE");
  end

  localparam logic [PEND_W-1:0] MAX_P = PEND_W'(MAX_POSTPONE);
  localparam logic [PEND_W-1:0] URG_P = PEND_W'(URGENT_THRESH);

  logic              expire;
  logic              ack_acc, ack_pend, tick_pend;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              overflow_q, overflow_d;
  logic              tick_q;
  ref_state_t        state_q, state_d;

  ref_interval_timer #(
    .CNT_W       (CNT_W),
    .REF_INTERVAL(REF_INTERVAL)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (expire)
  );

`ifdef SDRAM_REF_PULLIN_EN
  logic [PEND_W-1:0] pullin_q, pullin_d;
  logic              pull_req;

  // Pull-in request follows bank_idle directly so it withdraws the moment traffic returns.
  assign pull_req   = (pending_q == '0) && bank_idle && (pullin_q < MAX_P);
  assign ref_req    = (state_q != IDLE) || pull_req;
  assign pullin_cnt = pullin_q;
`else
  logic unused_bank_idle;
  assign unused_bank_idle = bank_idle;
  assign ref_req          = (state_q != IDLE);
`endif

  assign ack_acc = ref_ack && ref_req;

  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    ack_pend   = ack_acc;
    tick_pend  = expire;
`ifdef SDRAM_REF_PULLIN_EN
    pullin_d = pullin_q;
    if (ack_acc && pending_q == '0) begin
      ack_pend = 1'b0;
      pullin_d = pullin_d + PEND_W'(1);
    end
    // A banked pull-in credit absorbs the tick instead of creating a new debt.
    if (expire && pullin_d != '0) begin
      tick_pend = 1'b0;
      pullin_d  = pullin_d - PEND_W'(1);
    end
`endif
    case ({tick_pend, ack_pend})
      2'b10: begin
        if (pending_q == MAX_P) overflow_d = 1'b1;
        else                    pending_d  = pending_q + PEND_W'(1);
      end
      2'b01: begin
        if (pending_q != '0) pending_d = pending_q - PEND_W'(1);
      end
      default: ;
    endcase

    if (pending_d == '0)         state_d = IDLE;
    else if (pending_d >= URG_P) state_d = URGENT;
    else                         state_d = OWED;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
      tick_q     <= 1'b0;
      state_q    <= IDLE;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      tick_q     <= expire;
      state_q    <= state_d;
    end
  end

`ifdef SDRAM_REF_PULLIN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pullin_q <= '0;
    else        pullin_q <= pullin_d;
  end
`endif

  assign pending      = pending_q;
  assign tick         = tick_q;
  assign overflow_err = overflow_q;
  assign ref_urgent   = (state_q == URGENT);

endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
// Directed bench for sdram_refresh_scheduler with a 16-cycle refresh interval.
module tb_sdram_refresh_scheduler;

  localparam int PEND_W = 4;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              ref_ack;
  logic              bank_idle;
  logic              ref_req;
  logic              ref_urgent;
  logic [PEND_W-1:0] pending;
  logic              tick;
  logic              overflow_err;
`ifdef SDRAM_REF_PULLIN_EN
  logic [PEND_W-1:0] pullin_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  sdram_refresh_scheduler #(
    .CNT_W        (12),
    .REF_INTERVAL (16),
    .MAX_POSTPONE (8),
    .URGENT_THRESH(6),
    .PEND_W       (PEND_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .ref_ack     (ref_ack),
    .bank_idle   (bank_idle),
    .ref_req     (ref_req),
    .ref_urgent  (ref_urgent),
    .pending     (pending),
    .tick        (tick),
    .overflow_err(overflow_err)
`ifdef SDRAM_REF_PULLIN_EN
    ,
    .pullin_cnt  (pullin_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle at the following falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    step(target - cyc);
  endtask

  // Called at a falling edge: asserts reset between edges, checks the async
  // clear, and releases it between edges one period later.
  task automatic pulse_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    check({tag, "_pending"}, int'(pending), 0);
    check({tag, "_req"}, int'(ref_req), 0);
    check({tag, "_urgent"}, int'(ref_urgent), 0);
    check({tag, "_ovf"}, int'(overflow_err), 0);
    check({tag, "_tick"}, int'(tick), 0);
    #9 reset = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int nticks;
    reset     = 1'b0;
    enable    = 1'b1;
    ref_ack   = 1'b0;
    bank_idle = 1'b0;

    #12;
    check("rst_pending", int'(pending), 0);
    check("rst_req", int'(ref_req), 0);
    check("rst_urgent", int'(ref_urgent), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_ovf", int'(overflow_err), 0);

    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;

    // Ack with nothing owed is ignored.
    ref_ack = 1'b1;
    step(1);
    ref_ack = 1'b0;
    check("idle_ack_pending", int'(pending), 0);
    check("idle_ack_req", int'(ref_req), 0);

    run_to(15);
    check("pre_tick", int'(tick), 0);
    check("pre_tick_req", int'(ref_req), 0);
    run_to(16);
    check("tick16", int'(tick), 1);
    check("tick16_pending", int'(pending), 1);
    check("tick16_req", int'(ref_req), 1);
    check("tick16_urgent", int'(ref_urgent), 0);
    run_to(17);
    check("tick_pulse", int'(tick), 0);
    run_to(32);
    check("tick32_pending", int'(pending), 2);
    run_to(48);
    check("tick48_pending", int'(pending), 3);
    run_to(95);
    check("pend5_urgent", int'(ref_urgent), 0);
    run_to(96);
    check("tick96_pending", int'(pending), 6);
    check("tick96_urgent", int'(ref_urgent), 1);
    run_to(128);
    check("full_pending", int'(pending), 8);
    check("full_ovf", int'(overflow_err), 0);
    run_to(144);
    check("ovf_pending", int'(pending), 8);
    check("ovf_flag", int'(overflow_err), 1);

    ref_ack = 1'b1;
    step(1);
    check("ack_after_ovf_pending", int'(pending), 7);
    check("ack_after_ovf_flag", int'(overflow_err), 1);
    step(2);
    ref_ack = 1'b0;
    check("drain_pending", int'(pending), 5);
    check("drain_urgent", int'(ref_urgent), 0);

    // Async reset at pending=5; a late ack right after release must be ignored.
    pulse_reset("areset");
    ref_ack = 1'b1;
    step(1);
    ref_ack = 1'b0;
    check("late_ack_pending", int'(pending), 0);
    check("late_ack_req", int'(ref_req), 0);
    run_to(15);
    check("rel_pre_tick", int'(tick), 0);
    run_to(16);
    check("rel_tick", int'(tick), 1);
    check("rel_tick_pending", int'(pending), 1);

    // Ack coincident with tick leaves pending unchanged.
    run_to(63);
    ref_ack = 1'b1;
    step(1);
    ref_ack = 1'b0;
    check("coinc_tick", int'(tick), 1);
    check("coinc_pending", int'(pending), 3);
    check("coinc_ovf", int'(overflow_err), 0);
    check("coinc_req", int'(ref_req), 1);
    check("coinc_urgent", int'(ref_urgent), 0);

    // Disable mid-interval for 40 cycles, then expect a full fresh interval.
    run_to(70);
    enable = 1'b0;
    nticks = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (tick) nticks++;
    end
    check("dis_ticks", nticks, 0);
    check("dis_pending", int'(pending), 3);
    enable = 1'b1;
    step(15);
    check("reen_pre_tick", int'(tick), 0);
    step(1);
    check("reen_tick", int'(tick), 1);
    check("reen_pending", int'(pending), 4);

`ifdef SDRAM_REF_PULLIN_EN
    pulse_reset("pl_reset");
    bank_idle = 1'b1;
    #1;
    check("pl_req", int'(ref_req), 1);
    check("pl_urgent", int'(ref_urgent), 0);
    ref_ack = 1'b1;
    step(2);
    ref_ack = 1'b0;
    check("pl_cnt2", int'(pullin_cnt), 2);
    check("pl_pending0", int'(pending), 0);
    bank_idle = 1'b0;
    #1;
    check("pl_req_drop", int'(ref_req), 0);
    run_to(16);
    check("pl_t1_pending", int'(pending), 0);
    check("pl_t1_cnt", int'(pullin_cnt), 1);
    run_to(32);
    check("pl_t2_pending", int'(pending), 0);
    check("pl_t2_cnt", int'(pullin_cnt), 0);
    run_to(48);
    check("pl_t3_pending", int'(pending), 1);
    check("pl_t3_req", int'(ref_req), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
